// File: rtl/axis_fifo_s_pkg.sv
// Shared definitions for the AXI-Stream slave to FIFO write-side bridge:
// 3-bit FSM state encodings and a ceil(log2) helper for counter sizing.
package axis_fifo_s_pkg;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_INIT_COUNTER = 3'd1,
        ST_WAIT_SPACE   = 3'd2,
        ST_RECV         = 3'd3,
        ST_PAD          = 3'd4,
        ST_DRAIN        = 3'd5
    } state_t;

    // Number of bits needed to index 'value' items (ceil(log2(value))).
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_beat_counter.sv
// Per-frame word counter: cleared while waiting for FIFO space, advanced once
// per word written to the FIFO, flags the last word slot of a frame.
module axis_beat_counter
    import axis_fifo_s_pkg::*;
#(
    parameter int LENGTH_OF_FRAME = 1024,
    parameter int CNT_W           = clogb2(LENGTH_OF_FRAME) + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LENGTH_OF_FRAME - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == LAST_IDX);

endmodule

// File: rtl/axis_fifo_s_v1_0_s_axis.sv
// AXI-Stream slave that writes fixed-length frames into a FIFO write port.
// After reset it idles C_S_START_COUNT cycles, then per frame waits for
// prog_full to drop, accepts LENGTH_OF_FRAME beats, discards overlong tails
// and flags short frames. Build macro AXIS_FIFO_S_PAD_EN: when defined, a
// short frame is padded with zero words up to LENGTH_OF_FRAME; otherwise the
// partial frame is left in the FIFO as-is.
module axis_fifo_s_v1_0_s_axis
    import axis_fifo_s_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int C_S_START_COUNT      = 32,
    parameter int LENGTH_OF_FRAME      = 1024
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
    input  logic                              S_AXIS_TLAST,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   din,
    output logic                              wr_en,
    input  logic                              prog_full,
    input  logic                              full,
    output logic                              frame_done,
    output logic                              err_short,
    output logic                              err_long,
    output logic                              err_ovf,
    output logic [15:0]                       frame_cnt
);

    localparam int                   CNT_W      = clogb2(LENGTH_OF_FRAME) + 1;
    localparam int                   START_W    = clogb2(C_S_START_COUNT) + 1;
    localparam logic [START_W-1:0]   START_LAST = START_W'(C_S_START_COUNT - 1);

    state_t                          state_q;
    logic [START_W-1:0]              start_cnt_q;
    logic [C_S_AXIS_TDATA_WIDTH-1:0] din_q;
    logic                            wr_en_q;
    logic                            frame_done_q;
    logic                            err_short_q;
    logic                            err_long_q;
    logic                            err_ovf_q;
    logic [15:0]                     frame_cnt_q;

    logic                            tready;
    logic                            accept;
    logic                            cnt_clr;
    logic                            cnt_inc;
    logic                            cnt_tc;
    logic [CNT_W-1:0]                beat_cnt;
    logic                            unused_ok;

    // TKEEP carries no meaning here and the raw count is only needed for
    // the terminal flag; fold them into one sink.
    assign unused_ok = ^{S_AXIS_TKEEP, beat_cnt};

    // Ready only while receiving with room in the FIFO, or while discarding
    // the tail of an overlong frame (nothing is written then).
    assign tready = ((state_q == ST_RECV) && !full) || (state_q == ST_DRAIN);
    assign accept = S_AXIS_TVALID && tready;

    // The counter tracks words written: accepted beats in RECV plus pad words.
    assign cnt_clr = (state_q == ST_WAIT_SPACE);
    assign cnt_inc = ((state_q == ST_RECV) && accept) || (state_q == ST_PAD);

    axis_beat_counter #(
        .LENGTH_OF_FRAME(LENGTH_OF_FRAME),
        .CNT_W          (CNT_W)
    ) u_beat_counter (
        .clk_i  (S_AXIS_ACLK),
        .rst_i  (S_AXIS_ARESET),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .count_o(beat_cnt),
        .tc_o   (cnt_tc)
    );

    // Frame FSM with registered FIFO write port and single-cycle status pulses.
    always_ff @(posedge S_AXIS_ACLK) begin
        if (S_AXIS_ARESET) begin
            state_q      <= ST_IDLE;
            start_cnt_q  <= '0;
            din_q        <= '0;
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            wr_en_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            // A word presented while the FIFO reports full is lost; flag it,
            // the write itself is not retried.
            err_ovf_q    <= wr_en_q && full;

            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_INIT_COUNTER;
                end

                ST_INIT_COUNTER: begin
                    if (start_cnt_q == START_LAST) begin
                        state_q <= ST_WAIT_SPACE;
                    end else begin
                        start_cnt_q <= start_cnt_q + START_W'(1);
                    end
                end

                ST_WAIT_SPACE: begin
                    if (!prog_full) begin
                        state_q <= ST_RECV;
                    end
                end

                ST_RECV: begin
                    if (accept) begin
                        din_q   <= S_AXIS_TDATA;
                        wr_en_q <= 1'b1;
                        if (cnt_tc) begin
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 16'd1;
                            if (S_AXIS_TLAST) begin
                                state_q <= ST_WAIT_SPACE;
                            end else begin
                                err_long_q <= 1'b1;
                                state_q    <= ST_DRAIN;
                            end
                        end else if (S_AXIS_TLAST) begin
                            err_short_q <= 1'b1;
`ifdef AXIS_FIFO_S_PAD_EN
                            state_q     <= ST_PAD;
`else
                            state_q     <= ST_WAIT_SPACE;
`endif
                        end
                    end
                end

`ifdef AXIS_FIFO_S_PAD_EN
                ST_PAD: begin
                    din_q   <= '0;
                    wr_en_q <= 1'b1;
                    if (cnt_tc) begin
                        frame_done_q <= 1'b1;
                        frame_cnt_q  <= frame_cnt_q + 16'd1;
                        state_q      <= ST_WAIT_SPACE;
                    end
                end
`endif

                ST_DRAIN: begin
                    if (accept && S_AXIS_TLAST) begin
                        state_q <= ST_WAIT_SPACE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign S_AXIS_TREADY = tready;
    assign din           = din_q;
    assign wr_en         = wr_en_q;
    assign frame_done    = frame_done_q;
    assign err_short     = err_short_q;
    assign err_long      = err_long_q;
    assign err_ovf       = err_ovf_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_axis_fifo_s_v1_0_s_axis.sv
// Scoreboard bench for axis_fifo_s_v1_0_s_axis (LENGTH_OF_FRAME=8,
// C_S_START_COUNT=4). Stimulus pushes expected FIFO words and status pulse
// vectors; a negedge monitor pops and compares whenever the DUT presents them.
module tb_axis_fifo_s_v1_0_s_axis;

    logic        clk = 1'b0;
    logic        S_AXIS_ARESET;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic [3:0]  S_AXIS_TKEEP;
    logic        S_AXIS_TLAST;
    logic [31:0] din;
    logic        wr_en;
    logic        prog_full;
    logic        full;
    logic        frame_done;
    logic        err_short;
    logic        err_long;
    logic        err_ovf;
    logic [15:0] frame_cnt;

    int          tests = 0;
    int          fails = 0;
    int          exp_frames = 0;
    logic        mon_en = 1'b0;
    logic [31:0] exp_data[$];
    logic [3:0]  exp_ev[$];
    logic [31:0] mon_d;
    logic [3:0]  mon_ev;

    // event vector bits: {frame_done, err_short, err_long, err_ovf}
    localparam logic [3:0] EV_FD  = 4'b1000;
    localparam logic [3:0] EV_ES  = 4'b0100;
    localparam logic [3:0] EV_EL  = 4'b0010;
    localparam logic [3:0] EV_OVF = 4'b0001;

    always #5 clk = ~clk;

    axis_fifo_s_v1_0_s_axis #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .C_S_START_COUNT     (4),
        .LENGTH_OF_FRAME     (8)
    ) dut (
        .S_AXIS_ACLK  (clk),
        .S_AXIS_ARESET(S_AXIS_ARESET),
        .S_AXIS_TVALID(S_AXIS_TVALID),
        .S_AXIS_TREADY(S_AXIS_TREADY),
        .S_AXIS_TDATA (S_AXIS_TDATA),
        .S_AXIS_TKEEP (S_AXIS_TKEEP),
        .S_AXIS_TLAST (S_AXIS_TLAST),
        .din          (din),
        .wr_en        (wr_en),
        .prog_full    (prog_full),
        .full         (full),
        .frame_done   (frame_done),
        .err_short    (err_short),
        .err_long     (err_long),
        .err_ovf      (err_ovf),
        .frame_cnt    (frame_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every written word and every status pulse must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wr_en) begin
                if (exp_data.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got din %0h expected no write at %0t", din, $time);
                end else begin
                    mon_d = exp_data.pop_front();
                    check("din", din, mon_d);
                end
            end
            mon_ev = {frame_done, err_short, err_long, err_ovf};
            if (mon_ev != 4'b0000) begin
                if (exp_ev.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: got %b expected none at %0t", mon_ev, $time);
                end else begin
                    mon_ev = exp_ev.pop_front();
                    check("pulses", 32'({frame_done, err_short, err_long, err_ovf}), 32'(mon_ev));
                end
            end
        end
    end

    // Present one beat and hold it until accepted; then check whether it was written.
    task automatic send(input logic [31:0] d, input logic last, input logic written);
        int   n;
        logic rdy;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = d;
        S_AXIS_TLAST  = last;
        if (written) exp_data.push_back(d);
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = S_AXIS_TREADY;
            @(posedge clk);
            #1;
            n++;
        end
        if (!rdy) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: beat %0h got no ready expected ready within 50 cycles", d);
        end else begin
            check("wr_en_after_accept", 32'(wr_en), 32'(written));
        end
    endtask

    task automatic idle(input int n);
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TLAST  = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Full frame of 8 beats d0..d0+7 with TLAST on the 8th.
    task automatic frame8(input logic [31:0] d0);
        exp_frames++;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) exp_ev.push_back(EV_FD);
            send(d0 + 32'(i), (i == 7), 1'b1);
        end
    endtask

    // Reset with TVALID held high, then verify TREADY first rises 6 cycles after release.
    task automatic do_reset();
        S_AXIS_ARESET = 1'b1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 32'hA5;
        S_AXIS_TLAST  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_tready", 32'(S_AXIS_TREADY), 32'd0);
        check("rst_din", din, 32'd0);
        check("rst_pulses", 32'({frame_done, err_short, err_long, err_ovf}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        mon_en     = 1'b1;
        exp_frames = 0;
        @(posedge clk);
        #1;
        S_AXIS_ARESET = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("start_tready_c%0d", n), 32'(S_AXIS_TREADY), 32'(n == 6));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        S_AXIS_ARESET = 1'b1;
        S_AXIS_TVALID = 1'b0;
        S_AXIS_TDATA  = '0;
        S_AXIS_TKEEP  = 4'hF;
        S_AXIS_TLAST  = 1'b0;
        prog_full     = 1'b0;
        full          = 1'b0;
        @(posedge clk);
        #1;

        // startup latency, then first frame streamed straight in
        do_reset();
        frame8(32'h1);
        // hold off the next frame with prog_full for 10 cycles
        prog_full     = 1'b1;
        S_AXIS_TVALID = 1'b1;
        S_AXIS_TDATA  = 32'h11;
        S_AXIS_TLAST  = 1'b0;
        check("frame_cnt_f1", 32'(frame_cnt), 32'(exp_frames));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("tready_prog_full", 32'(S_AXIS_TREADY), 32'd0);
            @(posedge clk);
            #1;
        end
        prog_full = 1'b0;
        @(posedge clk);
        #1;
        check("tready_resume", 32'(S_AXIS_TREADY), 32'd1);
        frame8(32'h11);
        check("frame_cnt_f2", 32'(frame_cnt), 32'(exp_frames));

        // short frame of 3 beats
        send(32'h21, 1'b0, 1'b1);
        send(32'h22, 1'b0, 1'b1);
        exp_ev.push_back(EV_ES);
`ifdef AXIS_FIFO_S_PAD_EN
        exp_ev.push_back(EV_FD);
        exp_frames++;
        send(32'h23, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) exp_data.push_back(32'h0);
`else
        send(32'h23, 1'b1, 1'b1);
`endif
        idle(10);
        check("frame_cnt_short", 32'(frame_cnt), 32'(exp_frames));

        // overlong frame of 11 beats: 8 written, 3 discarded
        exp_frames++;
        for (int i = 0; i < 11; i++) begin
            if (i == 7) exp_ev.push_back(EV_FD | EV_EL);
            send(32'h31 + 32'(i), (i == 10), (i < 8));
        end
        check("frame_cnt_long", 32'(frame_cnt), 32'(exp_frames));
        frame8(32'h41);
        check("frame_cnt_aligned", 32'(frame_cnt), 32'(exp_frames));

        // full asserted while a word is being written
        exp_frames++;
        send(32'h51, 1'b0, 1'b1);
        send(32'h52, 1'b0, 1'b1);
        exp_ev.push_back(EV_OVF);
        full = 1'b1;
        @(negedge clk);
        check("tready_full", 32'(S_AXIS_TREADY), 32'd0);
        @(posedge clk);
        #1;
        full = 1'b0;
        for (int i = 2; i < 8; i++) begin
            if (i == 7) exp_ev.push_back(EV_FD);
            send(32'h51 + 32'(i), (i == 7), 1'b1);
        end
        check("frame_cnt_ovf", 32'(frame_cnt), 32'(exp_frames));

        // reset in the middle of a frame
        for (int i = 0; i < 4; i++) send(32'h61 + 32'(i), 1'b0, 1'b1);
        do_reset();
        frame8(32'h71);
        check("frame_cnt_after_rst", 32'(frame_cnt), 32'(exp_frames));

        idle(5);
        check("words_outstanding", 32'(exp_data.size()), 32'd0);
        check("pulses_outstanding", 32'(exp_ev.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_fifo_s_v1_0_s_axis.md
AXIS_FIFO_S_V1_0_S_AXIS -- requirements
Module: axis_fifo_s_v1_0_S_AXIS

Interface
REQ-001 SHALL have parameter C_S_AXIS_TDATA_WIDTH, default 32, TDATA/din width in bits.
REQ-002 SHALL have parameter C_S_START_COUNT, default 32, idle cycles after reset before first accept.
REQ-003 SHALL have parameter LENGTH_OF_FRAME, default 1024, beats per frame written to FIFO.
REQ-004 SHALL have one clock and a synchronous, active-high reset: S_AXIS_ACLK  in  1  clock; S_AXIS_ARESET  in  1  reset.
REQ-005 SHALL have S_AXIS_TVALID  in  1; S_AXIS_TREADY  out  1; S_AXIS_TDATA  in  C_S_AXIS_TDATA_WIDTH; S_AXIS_TKEEP  in  C_S_AXIS_TDATA_WIDTH/8 (ignored); S_AXIS_TLAST  in  1.
REQ-006 SHALL have FIFO write side: din  out  C_S_AXIS_TDATA_WIDTH; wr_en  out  1; prog_full  in  1; full  in  1.
REQ-007 SHALL have status: frame_done  out  1 pulse; err_short  out  1 pulse; err_long  out  1 pulse; err_ovf  out  1 pulse; frame_cnt  out  16 completed frames.

Function
REQ-008 SHALL implement states IDLE, INIT_COUNTER, WAIT_SPACE, RECV, PAD, DRAIN.
REQ-009 IDLE -> INIT_COUNTER unconditionally, one cycle after reset release.
REQ-010 INIT_COUNTER: count to C_S_START_COUNT-1, then -> WAIT_SPACE; never re-entered except via reset.
REQ-011 WAIT_SPACE: -> RECV when prog_full==0; beat counter cleared to 0; TREADY=0.
REQ-012 TREADY = (state==RECV) && !full, combinational; beat accepted when TVALID && TREADY.
REQ-013 Each accepted beat in RECV: din <= TDATA, wr_en <= 1 next cycle (latency 1); wr_en 0 otherwise.
REQ-014 Beat counter width clog2(LENGTH_OF_FRAME)+1; increments per written word (accepted or pad).
REQ-015 Accepted beat with count==LENGTH_OF_FRAME-1 and TLAST=1: frame complete -> WAIT_SPACE.
REQ-016 Accepted beat with count==LENGTH_OF_FRAME-1 and TLAST=0: frame complete, err_long pulse -> DRAIN.
REQ-017 DRAIN: TREADY=1, beats discarded (no wr_en) until accepted TLAST=1, then -> WAIT_SPACE.
REQ-018 Accepted beat with TLAST=1 and count<LENGTH_OF_FRAME-1: beat written, err_short pulse; next state per REQ-027/028.
REQ-019 frame_done pulses one cycle, frame_cnt increments (wraps 0xFFFF->0) when LENGTH_OF_FRAME words of a frame are written, incl. padded frames; not for unpadded short frames.
REQ-020 If full==1 coincides with a registered wr_en, word SHALL still be presented and err_ovf pulse; no retry.
REQ-021 Error pulses and frame_done SHALL be single-cycle, registered; simultaneous errors pulse together.
REQ-022 Integration rule: FIFO prog_full threshold <= depth-LENGTH_OF_FRAME-2 so full never asserts mid-frame.

Reset
REQ-023 S_AXIS_ARESET sampled at S_AXIS_ACLK rising edge only; forces state IDLE, start count 0, beat counter 0.
REQ-024 Reset values: TREADY 0, wr_en 0, din 0, frame_done/err_* 0, frame_cnt 0.
REQ-025 Reset mid-frame SHALL abandon frame immediately; no pad, no pulses; pending wr_en cleared.
REQ-026 TREADY SHALL stay 0 until INIT_COUNTER completes.

Configuration
REQ-027 With macro AXIS_FIFO_S_PAD_EN defined: short frame -> PAD; PAD writes din=0, wr_en=1 each cycle, TREADY=0, until LENGTH_OF_FRAME words written, then frame_done, -> WAIT_SPACE.
REQ-028 Without AXIS_FIFO_S_PAD_EN: PAD state unreachable; short frame -> WAIT_SPACE, partial frame left in FIFO, no frame_done.

Structure
REQ-029 Package axis_fifo_s_pkg SHALL hold state encodings (3-bit) and clogb2 function.
REQ-030 Beat counter SHALL be one sub-module axis_beat_counter (clear, inc, terminal-count flag).
REQ-031 All other logic inline; no internal storage beyond din register.

Verification (bench LENGTH_OF_FRAME=8, C_S_START_COUNT=4)
REQ-032 Reset release, TVALID held 1 -> TREADY first high at cycle 6 (IDLE+4 count+WAIT_SPACE); none earlier.
REQ-033 8 beats 0x1..0x8, TLAST on 8th -> wr_en 8 cycles, din 0x1..0x8 lagging handshake by 1, frame_done once, frame_cnt=1.
REQ-034 prog_full=1 at frame start for 10 cycles -> TREADY 0 throughout; accepts resume cycle after prog_full falls.
REQ-035 3 beats, TLAST on 3rd, PAD_EN on -> err_short, 5 zero words written, frame_done, frame_cnt+1; PAD_EN off -> err_short, 3 words only, frame_cnt unchanged.
REQ-036 11 beats, TLAST on 11th -> 8 words written, err_long at 8th, beats 9-11 discarded, next frame aligned.
REQ-037 Reset asserted after 4th beat -> wr_en 0 next cycle, no pulses, restart per REQ-032.
